// File: rtl/rv32_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv32_ctrl_pkg
// Shared encodings for the multicycle RV32 control path: FSM state codes,
// opcodes, ALU operation codes, datapath mux selects and trap causes.
// The state codes are plain localparam constants so that legacy RTL and
// scripts which compare against raw 4-bit values keep working.
// -----------------------------------------------------------------------------
package rv32_ctrl_pkg;

    // FSM state encoding
    typedef logic [3:0] state_t;

    localparam state_t FETCH  = 4'd0;
    localparam state_t DECODE = 4'd1;
    localparam state_t MEMADR = 4'd2;
    localparam state_t MEMRD  = 4'd3;
    localparam state_t MEMWB  = 4'd4;
    localparam state_t MEMWR  = 4'd5;
    localparam state_t EXEC_R = 4'd6;
    localparam state_t EXEC_I = 4'd7;
    localparam state_t ALUWB  = 4'd8;
    localparam state_t BRANCH = 4'd9;
    localparam state_t JAL    = 4'd10;
    localparam state_t JALR   = 4'd11;
    localparam state_t TRAP   = 4'd12;

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation codes driven outside the R/I execute states
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_CMP = 4'b0001;

    // Datapath mux selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that sit waiting on mem_ready and are covered by the watchdog
    function automatic logic is_mem_wait(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation select for the multicycle control FSM.
// Ports:
//   state    in  4  current FSM state
//   funct3   in  3  instruction funct3
//   funct7   in  1  instruction bit 30
//   alu_ctrl out 4  ALU operation
// -----------------------------------------------------------------------------
module alu_decoder
    import rv32_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    output logic [3:0]  alu_ctrl
);

    always_comb begin
        // NOTE: default first so every path assigns alu_ctrl; no latch is inferred.
        alu_ctrl = ALU_ADD;
        case (state)
            EXEC_R: alu_ctrl = {funct7, funct3};
            // Bit 30 only selects SRAI vs SRLI among the immediate ops; for the
            // rest it is part of the immediate and must not leak into the op.
            EXEC_I: alu_ctrl = (funct3 == 3'b101) ? {funct7, 3'b101} : {1'b0, funct3};
            BRANCH: alu_ctrl = ALU_CMP;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_fsm
// Control FSM for a multicycle RV32 datapath with a memory watchdog and a
// sticky trap state.
// Parameters:
//   MEM_TIMEOUT  wait cycles allowed for mem_ready before trapping (1..65535)
// Build option:
//   PERF_CNT_EN  when defined, adds the 32-bit retired-instruction counter
//                output instret
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   op/funct3/funct7  instruction fields from the instruction register
//   zero              ALU zero flag (branch condition)
//   mem_ready         memory transfer complete
//   pc_we, ir_we      PC / instruction register write enables
//   mem_req, mem_we   memory request / write
//   reg_we            register file write enable
//   alu_src_a/b       ALU operand selects
//   imm_src           immediate format select
//   result_src        result mux select
//   alu_ctrl          ALU operation
//   trap, trap_cause  sticky fault flag and its cause
//   instret           retired instruction count (PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module multicycle_fsm
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_ctrl,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state, state_next;
    logic [15:0] wait_cnt;
    logic        trap_q;
    logic [1:0]  cause_q, cause_next;
    logic        timeout;
    logic        branch_taken;
    logic [3:0]  dec_alu_ctrl;

    // The last permitted wait cycle also ends without mem_ready.
    assign timeout = is_mem_wait(state) && !mem_ready && (wait_cnt == TIMEOUT_LAST);

    assign branch_taken = ((funct3 == 3'b000) &&  zero) ||
                          ((funct3 == 3'b001) && !zero);

    // Next-state logic
    always_comb begin
        state_next = state;
        cause_next = cause_q;
        case (state)
            FETCH:  if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_next = MEMADR;
                    OP_R:      state_next = EXEC_R;
                    OP_I:      state_next = EXEC_I;
                    OP_BRANCH: state_next = BRANCH;
                    OP_JAL:    state_next = JAL;
                    OP_JALR:   state_next = JALR;
                    default: begin
                        state_next = TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            MEMADR: state_next = (op == OP_STORE) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_next = MEMWB;
            MEMWR:  if (mem_ready) state_next = FETCH;
            EXEC_R,
            EXEC_I: state_next = ALUWB;
            ALUWB,
            MEMWB,
            BRANCH,
            JAL,
            JALR:   state_next = FETCH;
            TRAP:   state_next = TRAP;
            default: state_next = FETCH;
        endcase

        if (timeout) begin
            state_next = TRAP;
            cause_next = CAUSE_TIMEOUT;
        end
    end

    // State, watchdog and trap registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge.
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
            if (state_next == TRAP) trap_q <= 1'b1;
            // Any state change clears the count, so each wait state starts at 0.
            if (state_next != state)
                wait_cnt <= '0;
            else if (is_mem_wait(state) && !mem_ready)
                wait_cnt <= wait_cnt + 16'd1;
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            instret <= '0;
        else if ((state != FETCH) && (state_next == FETCH))
            instret <= instret + 32'd1;
    end
`endif

    alu_decoder u_alu_decoder (
        .state    (state),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_ctrl (dec_alu_ctrl)
    );

    // Control outputs. Everything is held at 0 while rst_n is low so the
    // datapath sees no enables before the first edge has initialised state.
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    if (mem_ready) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_B;
                end
                MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
                end
                MEMRD:  mem_req = 1'b1;
                MEMWB: begin
                    reg_we     = 1'b1;
                    result_src = RES_MEM;
                end
                MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                EXEC_R: alu_src_a = SRCA_RS1;
                EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                ALUWB:  reg_we = 1'b1;
                BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    pc_we     = branch_taken;
                end
                JAL: begin
                    pc_we     = 1'b1;
                    reg_we    = 1'b1;
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_J;
                end
                JALR: begin
                    pc_we     = 1'b1;
                    reg_we    = 1'b1;
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_I;
                end
                default: ;
            endcase
        end
    end

    assign alu_ctrl   = rst_n ? dec_alu_ctrl : ALU_ADD;
    assign trap       = rst_n & trap_q;
    assign trap_cause = rst_n ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_multicycle_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_fsm
// Directed bench for multicycle_fsm (MEM_TIMEOUT = 4). The stimulus process
// drives one cycle at a time and queues the control word expected in that
// cycle; a monitor on the falling edge pops and compares it.
// Expected enables are packed as {pc_we, ir_we, mem_req, mem_we, reg_we} and
// the mux selects as {alu_src_a, alu_src_b, imm_src} with a care mask.
// -----------------------------------------------------------------------------
module tb_multicycle_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        zero;
    logic        mem_ready;
    logic        pc_we, ir_we, mem_req, mem_we, reg_we;
    logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
    logic [3:0]  alu_ctrl;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] act_ic;
`ifdef PERF_CNT_EN
    logic [31:0] instret;
    assign act_ic = instret;
`else
    assign act_ic = 32'd0;
`endif

    always #5 clk = ~clk;

    multicycle_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .result_src (result_src),
        .alu_ctrl   (alu_ctrl),
        .trap       (trap),
        .trap_cause (trap_cause)
`ifdef PERF_CNT_EN
        ,
        .instret    (instret)
`endif
    );

    typedef struct {
        string       tag;
        logic [4:0]  en;
        logic [3:0]  alu;
        logic [1:0]  rs;
        logic        rs_care;
        logic [5:0]  mux;
        logic [5:0]  mux_mask;
        logic        trp;
        logic [1:0]  cause;
        logic [31:0] ic;
        logic        ic_care;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   vectors     = 0;
    int   miscompares = 0;

    // ---------------- expected control words (hand-derived) ----------------
    function automatic exp_t mk(input string tag, input logic [4:0] en, input logic [3:0] alu);
        exp_t e;
        e.tag = tag;  e.en = en;  e.alu = alu;
        e.rs = 2'b00; e.rs_care = 1'b0;
        e.mux = 6'b0; e.mux_mask = 6'b0;
        e.trp = 1'b0; e.cause = 2'b00;
        e.ic = 32'd0; e.ic_care = 1'b0;
        return e;
    endfunction

    function automatic exp_t x_reset();   return mk("reset", 5'b00000, 4'b0000); endfunction
    function automatic exp_t x_fwait();   return mk("fetch_wait", 5'b00100, 4'b0000); endfunction
    function automatic exp_t x_frdy();
        exp_t e = mk("fetch_ready", 5'b11100, 4'b0000);
        e.rs = 2'b10; e.rs_care = 1'b1;
        e.mux = 6'b00_10_00; e.mux_mask = 6'b11_11_00;
        return e;
    endfunction
    function automatic exp_t x_dec();
        exp_t e = mk("decode", 5'b00000, 4'b0000);
        e.mux = 6'b01_01_10; e.mux_mask = 6'b11_11_11;
        return e;
    endfunction
    function automatic exp_t x_memadr();  return mk("memadr", 5'b00000, 4'b0000); endfunction
    function automatic exp_t x_memrd();   return mk("memrd", 5'b00100, 4'b0000); endfunction
    function automatic exp_t x_memwr();   return mk("memwr", 5'b00110, 4'b0000); endfunction
    function automatic exp_t x_memwb();
        exp_t e = mk("memwb", 5'b00001, 4'b0000);
        e.rs = 2'b01; e.rs_care = 1'b1;
        return e;
    endfunction
    function automatic exp_t x_aluwb();   return mk("aluwb", 5'b00001, 4'b0000); endfunction
    function automatic exp_t x_branch(input logic taken);
        return mk(taken ? "branch_taken" : "branch_not_taken", {taken, 4'b0000}, 4'b0001);
    endfunction
    function automatic exp_t x_jal();
        exp_t e = mk("jal", 5'b10001, 4'b0000);
        e.rs = 2'b00; e.rs_care = 1'b1;
        return e;
    endfunction
    function automatic exp_t x_jalr();
        exp_t e = mk("jalr", 5'b10001, 4'b0000);
        e.rs = 2'b00; e.rs_care = 1'b1;
        e.mux = 6'b10_01_00; e.mux_mask = 6'b11_11_11;
        return e;
    endfunction
    function automatic exp_t x_trap(input logic [1:0] cause);
        exp_t e = mk("trap", 5'b00000, 4'b0000);
        e.trp = 1'b1; e.cause = cause;
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7 = f7;
    endtask

    // Drive one cycle's inputs and queue the control word expected in it.
    task automatic cyc(input exp_t e, input logic rdy, input logic z);
        mem_ready = rdy;
        zero      = z;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / checker ----------------
    task automatic check(input exp_t e);
        logic [4:0] act_en;
        logic [5:0] act_mux;
        logic       bad;
        act_en  = {pc_we, ir_we, mem_req, mem_we, reg_we};
        act_mux = {alu_src_a, alu_src_b, imm_src};
        bad = (act_en !== e.en) || (alu_ctrl !== e.alu) ||
              (trap !== e.trp) || (trap_cause !== e.cause) ||
              (e.rs_care && (result_src !== e.rs)) ||
              (((act_mux ^ e.mux) & e.mux_mask) !== 6'b0) ||
              (e.ic_care && (act_ic !== e.ic));
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s @%0t: got en=%b alu=%b rs=%b mux=%b trap=%b cause=%b ic=%0d, want en=%b alu=%b rs=%b mux=%b/%b trap=%b cause=%b ic=%0d",
                     e.tag, $time, act_en, alu_ctrl, result_src, act_mux, trap, trap_cause, act_ic,
                     e.en, e.alu, e.rs, e.mux, e.mux_mask, e.trp, e.cause, e.ic);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check(cur);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        exp_t e;
        rst_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with mem_ready high: enables and trap must still read 0
        cyc(x_reset(), 1'b1, 1'b0);
        rst_n = 1'b1;

        // ADD: FETCH, DECODE, EXEC_R, ALUWB
        instr(7'b0110011, 3'b000, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0);
        cyc(x_dec(), 1'b0, 1'b0);
        cyc(mk("exec_r_add", 5'b00000, 4'b0000), 1'b0, 1'b0);
        cyc(x_aluwb(), 1'b0, 1'b0);

        // SUB: funct7 passes through in EXEC_R
        instr(7'b0110011, 3'b000, 1'b1);
        cyc(x_frdy(), 1'b1, 1'b0);
        cyc(x_dec(), 1'b0, 1'b0);
        cyc(mk("exec_r_sub", 5'b00000, 4'b1000), 1'b0, 1'b0);
        cyc(x_aluwb(), 1'b0, 1'b0);

        // SRAI with one fetch wait cycle: funct7 kept for funct3=101
        instr(7'b0010011, 3'b101, 1'b1);
        cyc(x_fwait(), 1'b0, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0);
        cyc(x_dec(), 1'b0, 1'b0);
        cyc(mk("exec_i_srai", 5'b00000, 4'b1101), 1'b0, 1'b0);
        cyc(x_aluwb(), 1'b0, 1'b0);

        // XORI with bit 30 set: funct7 dropped
        instr(7'b0010011, 3'b100, 1'b1);
        cyc(x_frdy(), 1'b1, 1'b0);
        cyc(x_dec(), 1'b0, 1'b0);
        cyc(mk("exec_i_xori", 5'b00000, 4'b0100), 1'b0, 1'b0);
        cyc(x_aluwb(), 1'b0, 1'b0);

        // LW: stray mem_ready in DECODE/MEMADR ignored, 3 wait cycles in MEMRD
        instr(7'b0000011, 3'b010, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0);
        cyc(x_dec(), 1'b1, 1'b0);
        cyc(x_memadr(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(x_memrd(), 1'b0, 1'b0);
        cyc(x_memrd(), 1'b1, 1'b0);
        cyc(x_memwb(), 1'b1, 1'b0);

        // SW: one wait cycle in MEMWR, then straight back to FETCH
        instr(7'b0100011, 3'b010, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0);
        cyc(x_dec(), 1'b0, 1'b0);
        cyc(x_memadr(), 1'b0, 1'b0);
        cyc(x_memwr(), 1'b0, 1'b0);
        cyc(x_memwr(), 1'b1, 1'b0);

        // Branches: BEQ/BNE both polarities, BLT never taken
        instr(7'b1100011, 3'b000, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0); cyc(x_dec(), 1'b0, 1'b0); cyc(x_branch(1'b1), 1'b0, 1'b1);
        cyc(x_frdy(), 1'b1, 1'b0); cyc(x_dec(), 1'b0, 1'b0); cyc(x_branch(1'b0), 1'b0, 1'b0);
        instr(7'b1100011, 3'b001, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0); cyc(x_dec(), 1'b0, 1'b0); cyc(x_branch(1'b1), 1'b0, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0); cyc(x_dec(), 1'b0, 1'b0); cyc(x_branch(1'b0), 1'b0, 1'b1);
        instr(7'b1100011, 3'b100, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0); cyc(x_dec(), 1'b0, 1'b0); cyc(x_branch(1'b0), 1'b0, 1'b1);

        // JAL and JALR
        instr(7'b1101111, 3'b000, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0); cyc(x_dec(), 1'b0, 1'b0); cyc(x_jal(), 1'b0, 1'b0);
        instr(7'b1100111, 3'b000, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0); cyc(x_dec(), 1'b0, 1'b0); cyc(x_jalr(), 1'b0, 1'b0);

        // Illegal opcode: sticky trap for 20 cycles despite mem_ready/zero activity
        instr(7'b1111111, 3'b000, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0);
        cyc(x_dec(), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(x_trap(2'b01), logic'(i % 2), logic'(i % 3 == 0));

        // One reset cycle leaves TRAP; then fetch times out after 4 wait cycles
        rst_n = 1'b0;
        cyc(x_reset(), 1'b0, 1'b0);
        rst_n = 1'b1;
        instr(7'b0110011, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) cyc(x_fwait(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(x_trap(2'b10), logic'(i % 2), 1'b0);

        // Load data phase times out the same way
        rst_n = 1'b0;
        cyc(x_reset(), 1'b0, 1'b0);
        rst_n = 1'b1;
        instr(7'b0000011, 3'b010, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0);
        cyc(x_dec(), 1'b0, 1'b0);
        cyc(x_memadr(), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(x_memrd(), 1'b0, 1'b0);
        cyc(x_trap(2'b10), 1'b0, 1'b0);

`ifdef PERF_CNT_EN
        // Five retired instructions, then reset in the middle of a store
        rst_n = 1'b0;
        cyc(x_reset(), 1'b0, 1'b0);
        rst_n = 1'b1;
        instr(7'b0110011, 3'b000, 1'b0);
        for (int n = 0; n < 5; n++) begin
            e = x_frdy(); e.ic = 32'(n); e.ic_care = 1'b1;
            cyc(e, 1'b1, 1'b0);
            cyc(x_dec(), 1'b0, 1'b0);
            cyc(mk("exec_r_add", 5'b00000, 4'b0000), 1'b0, 1'b0);
            cyc(x_aluwb(), 1'b0, 1'b0);
        end
        instr(7'b0100011, 3'b010, 1'b0);
        cyc(x_frdy(), 1'b1, 1'b0);
        cyc(x_dec(), 1'b0, 1'b0);
        cyc(x_memadr(), 1'b0, 1'b0);
        e = x_memwr(); e.tag = "instret_before_reset"; e.ic = 32'd5; e.ic_care = 1'b1;
        cyc(e, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(x_reset(), 1'b0, 1'b0);
        rst_n = 1'b1;
        e = x_fwait(); e.tag = "instret_after_reset"; e.ic = 32'd0; e.ic_care = 1'b1;
        cyc(e, 1'b0, 1'b0);
`endif

        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
